// File: rtl/rnd_pkg.sv
// Shared types, default widths and the rounding-increment decision for the
// pipelined rounding unit.
package rnd_pkg;

  typedef enum logic [2:0] {
    RNE = 3'd0,
    RTZ = 3'd1,
    RDN = 3'd2,
    RUP = 3'd3,
    RMM = 3'd4
  } rnd_mode_e;

  localparam int RND_MANT_W = 23;
  localparam int RND_EXP_W  = 8;
  localparam int MANT_DW    = RND_MANT_W + 1;
  localparam int EXP_MAX    = (1 << RND_EXP_W) - 1;

  // Whether the magnitude is bumped by one ulp; unknown modes behave as RNE.
  function automatic logic rnd_decide(input logic [2:0] mode, input logic sign,
                                      input logic lsb, input logic g, input logic s);
    logic inc;
    case (mode)
      RTZ:     inc = 1'b0;
      RDN:     inc = sign & (g | s);
      RUP:     inc = ~sign & (g | s);
      RMM:     inc = g;
      default: inc = g & (s | lsb);
    endcase
    return inc;
  endfunction

  // On overflow, these modes round away to infinity; the others clamp to max finite.
  function automatic logic rnd_to_inf(input logic [2:0] mode, input logic sign);
    logic to_inf;
    case (mode)
      RTZ:     to_inf = 1'b0;
      RDN:     to_inf = sign;
      RUP:     to_inf = ~sign;
      default: to_inf = 1'b1;
    endcase
    return to_inf;
  endfunction

endpackage

// File: rtl/rnd_pipe_unit_rnd_inc.sv
// Parametrised incrementer: each sum bit sees the carry-in ANDed with all
// lower operand bits, so no bit waits on a rippled carry.
module rnd_inc #(
  parameter int WIDTH = 24
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic             i_cin,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout
);

  logic [WIDTH-1:0] carry;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      if (gi == 0) begin : g_lsb
        assign carry[gi] = i_cin;
      end else begin : g_upper
        assign carry[gi] = i_cin & (&i_a[gi-1:0]);
      end
      assign o_sum[gi] = i_a[gi] ^ carry[gi];
    end
  endgenerate

  assign o_cout = i_cin & (&i_a);

endmodule

// File: rtl/rnd_pipe_unit.sv
// Two-stage rounding pipeline: stage 1 captures the operand and decides the
// increment, stage 2 applies it with renormalisation and overflow handling.
module rnd_pipe_unit
  import rnd_pkg::*;
#(
  parameter int MANT_W = MANT_DW - 1,
  parameter int EXP_W  = $clog2(EXP_MAX + 1)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic              i_sign,
  input  logic [EXP_W-1:0]  i_exp,
  input  logic [MANT_W:0]   i_mant,
  input  logic              i_guard,
  input  logic              i_sticky,
  input  logic [2:0]        i_mode,
  output logic              o_valid,
  input  logic              i_ready,
  output logic              o_sign,
  output logic [EXP_W-1:0]  o_exp,
  output logic [MANT_W:0]   o_mant,
  output logic              o_inexact,
  output logic              o_overflow
);

  localparam logic [EXP_W-1:0] EMAX = '1;

  logic en1, en2;

  logic              v1_q, v1_d;
  logic              s1_sign_q, s1_sign_d;
  logic [EXP_W-1:0]  s1_exp_q, s1_exp_d;
  logic [MANT_W:0]   s1_mant_q, s1_mant_d;
  logic              s1_inc_q, s1_inc_d;
  logic              s1_inexact_q, s1_inexact_d;
  logic              s1_special_q, s1_special_d;
  logic              s1_to_inf_q, s1_to_inf_d;

  logic              v2_q, v2_d;
  logic              out_sign_q, out_sign_d;
  logic [EXP_W-1:0]  out_exp_q, out_exp_d;
  logic [MANT_W:0]   out_mant_q, out_mant_d;
  logic              out_inexact_q, out_inexact_d;
  logic              out_overflow_q, out_overflow_d;

  logic [MANT_W:0]   inc_sum;
  logic              inc_cout;

  // Backpressure ripples straight through; a full pipe drains and refills in one cycle.
  assign en2     = ~v2_q | i_ready;
  assign en1     = ~v1_q | en2;
  assign o_ready = en1;

  always_comb begin
    v1_d         = v1_q;
    s1_sign_d    = s1_sign_q;
    s1_exp_d     = s1_exp_q;
    s1_mant_d    = s1_mant_q;
    s1_inc_d     = s1_inc_q;
    s1_inexact_d = s1_inexact_q;
    s1_special_d = s1_special_q;
    s1_to_inf_d  = s1_to_inf_q;
    if (en1) begin
      v1_d         = i_valid;
      s1_sign_d    = i_sign;
      s1_exp_d     = i_exp;
      s1_mant_d    = i_mant;
      s1_special_d = (i_exp == EMAX);
      s1_inc_d     = (i_exp != EMAX) & rnd_decide(i_mode, i_sign, i_mant[0], i_guard, i_sticky);
      s1_inexact_d = (i_exp != EMAX) & (i_guard | i_sticky);
      s1_to_inf_d  = rnd_to_inf(i_mode, i_sign);
    end
  end

  rnd_inc #(.WIDTH(MANT_W + 1)) u_inc (
    .i_a    (s1_mant_q),
    .i_cin  (s1_inc_q),
    .o_sum  (inc_sum),
    .o_cout (inc_cout)
  );

  always_comb begin
    v2_d           = v2_q;
    out_sign_d     = out_sign_q;
    out_exp_d      = out_exp_q;
    out_mant_d     = out_mant_q;
    out_inexact_d  = out_inexact_q;
    out_overflow_d = out_overflow_q;
    if (en2) begin
      v2_d           = v1_q;
      out_sign_d     = s1_sign_q;
      out_exp_d      = s1_exp_q;
      out_mant_d     = inc_sum;
      out_inexact_d  = s1_inexact_q;
      out_overflow_d = 1'b0;
      if (inc_cout) begin
        out_mant_d = {1'b1, {MANT_W{1'b0}}};
        out_exp_d  = s1_exp_q + 1'b1;
      end else if ((s1_exp_q == '0) && inc_sum[MANT_W] && !s1_mant_q[MANT_W]) begin
        out_exp_d = EXP_W'(1);
      end
      // A finite operand that rounded up into the Inf/NaN exponent.
      if (!s1_special_q && (out_exp_d == EMAX)) begin
        out_overflow_d = 1'b1;
        out_inexact_d  = 1'b1;
        if (s1_to_inf_q) begin
          out_mant_d = '0;
        end else begin
          out_exp_d  = EMAX - 1'b1;
          out_mant_d = '1;
        end
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      v1_q           <= 1'b0;
      s1_sign_q      <= 1'b0;
      s1_exp_q       <= '0;
      s1_mant_q      <= '0;
      s1_inc_q       <= 1'b0;
      s1_inexact_q   <= 1'b0;
      s1_special_q   <= 1'b0;
      s1_to_inf_q    <= 1'b0;
      v2_q           <= 1'b0;
      out_sign_q     <= 1'b0;
      out_exp_q      <= '0;
      out_mant_q     <= '0;
      out_inexact_q  <= 1'b0;
      out_overflow_q <= 1'b0;
    end else begin
      v1_q           <= v1_d;
      s1_sign_q      <= s1_sign_d;
      s1_exp_q       <= s1_exp_d;
      s1_mant_q      <= s1_mant_d;
      s1_inc_q       <= s1_inc_d;
      s1_inexact_q   <= s1_inexact_d;
      s1_special_q   <= s1_special_d;
      s1_to_inf_q    <= s1_to_inf_d;
      v2_q           <= v2_d;
      out_sign_q     <= out_sign_d;
      out_exp_q      <= out_exp_d;
      out_mant_q     <= out_mant_d;
      out_inexact_q  <= out_inexact_d;
      out_overflow_q <= out_overflow_d;
    end
  end

  assign o_valid    = v2_q;
  assign o_sign     = out_sign_q;
  assign o_exp      = out_exp_q;
  assign o_mant     = out_mant_q;
  assign o_inexact  = out_inexact_q;
  assign o_overflow = out_overflow_q;

endmodule

// File: tb/tb_rnd_pipe_unit.sv
// Randomised and directed bench for rnd_pipe_unit, scored against an
// arithmetic rounding model and a queue of in-flight beats.
module tb_rnd_pipe_unit;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [23:0] mant;
    logic        g;
    logic        s;
    logic [2:0]  mode;
  } in_t;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [23:0] mant;
    logic        inexact;
    logic        ovf;
  } out_t;

  typedef struct {
    out_t o;
    int   t;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_valid, o_ready, i_ready;
  logic        i_sign, i_guard, i_sticky;
  logic [7:0]  i_exp;
  logic [23:0] i_mant;
  logic [2:0]  i_mode;
  logic        o_valid, o_sign, o_inexact, o_overflow;
  logic [7:0]  o_exp;
  logic [23:0] o_mant;

  logic        c2_valid, c2_oready, c2_ovalid, c2_osign, c2_oinexact, c2_ooverflow;
  logic [10:0] c2_exp, c2_oexp;
  logic [52:0] c2_mant, c2_omant;

  int   n_vec = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   st_lo = 1 << 30;
  int   st_hi = 0;
  bit   rand_rdy = 1'b0;
  bit   saw_block = 1'b0;
  bit   prev_stall = 1'b0;
  out_t prev_o;
  ent_t q[$];

  always #5 clk = ~clk;

  rnd_pipe_unit #(.MANT_W(23), .EXP_W(8)) dut (
    .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_sign(i_sign), .i_exp(i_exp), .i_mant(i_mant), .i_guard(i_guard),
    .i_sticky(i_sticky), .i_mode(i_mode), .o_valid(o_valid), .i_ready(i_ready),
    .o_sign(o_sign), .o_exp(o_exp), .o_mant(o_mant), .o_inexact(o_inexact),
    .o_overflow(o_overflow)
  );

  rnd_pipe_unit #(.MANT_W(52), .EXP_W(11)) dut2 (
    .i_clk(clk), .i_rst(rst), .i_valid(c2_valid), .o_ready(c2_oready),
    .i_sign(1'b0), .i_exp(c2_exp), .i_mant(c2_mant), .i_guard(1'b1),
    .i_sticky(1'b0), .i_mode(3'd0), .o_valid(c2_ovalid), .i_ready(1'b1),
    .o_sign(c2_osign), .o_exp(c2_oexp), .o_mant(c2_omant), .o_inexact(c2_oinexact),
    .o_overflow(c2_ooverflow)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    n_vec++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  function automatic out_t model(input in_t x);
    out_t   r;
    bit     up;
    bit     to_max;
    longint m;
    int     e;
    r.sign = x.sign;
    if (x.exp == 8'hFF) begin
      r.exp = x.exp; r.mant = x.mant; r.inexact = 1'b0; r.ovf = 1'b0;
      return r;
    end
    case (x.mode)
      3'd1:    up = 1'b0;
      3'd2:    up = x.sign && (x.g || x.s);
      3'd3:    up = !x.sign && (x.g || x.s);
      3'd4:    up = x.g;
      default: up = x.g && (x.s || x.mant[0]);
    endcase
    m = longint'(x.mant) + (up ? 64'd1 : 64'd0);
    e = int'(x.exp);
    if (m == 64'h1000000) begin
      m = 64'h800000;
      e = e + 1;
    end else if (e == 0 && x.mant < 24'h800000 && m >= 64'h800000) begin
      e = 1;
    end
    r.inexact = x.g || x.s;
    r.ovf     = 1'b0;
    if (e == 255) begin
      r.ovf = 1'b1; r.inexact = 1'b1;
      to_max = (x.mode == 3'd1) || (x.mode == 3'd3 && x.sign) || (x.mode == 3'd2 && !x.sign);
      if (to_max) begin
        e = 254; m = 64'hFFFFFF;
      end else begin
        m = 0;
      end
    end
    r.exp  = 8'(e);
    r.mant = 24'(m);
    return r;
  endfunction

  task automatic cmp_out(input string tag, input out_t want);
    chk({tag, "_sign"}, 64'(o_sign), 64'(want.sign));
    chk({tag, "_exp"}, 64'(o_exp), 64'(want.exp));
    chk({tag, "_mant"}, 64'(o_mant), 64'(want.mant));
    chk({tag, "_inexact"}, 64'(o_inexact), 64'(want.inexact));
    chk({tag, "_overflow"}, 64'(o_overflow), 64'(want.ovf));
  endtask

  // Per-cycle scoreboard: occupancy predicts o_ready/o_valid, the queue predicts data.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      chk("o_ready", 64'(o_ready), 64'(!(q.size() == 2 && !i_ready)));
      chk("o_valid", 64'(o_valid), 64'(q.size() > 0 && (cyc - q[0].t) >= 2));
      if (prev_stall) cmp_out("stall_hold", prev_o);
      if (o_valid && i_ready && q.size() > 0) begin
        cmp_out("beat", q[0].o);
        void'(q.pop_front());
      end
      prev_stall = o_valid && !i_ready;
      prev_o     = '{o_sign, o_exp, o_mant, o_inexact, o_overflow};
      if (i_valid && o_ready)
        q.push_back('{model('{i_sign, i_exp, i_mant, i_guard, i_sticky, i_mode}), cyc});
    end
  end

  initial begin
    i_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (cyc >= st_lo && cyc <= st_hi) i_ready = 1'b0;
      else if (rand_rdy)                i_ready = ($urandom_range(0, 3) != 0);
      else                              i_ready = 1'b1;
    end
  end

  task automatic send(input in_t x);
    bit ok = 1'b0;
    {i_sign, i_exp, i_mant, i_guard, i_sticky, i_mode} = x;
    i_valid = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (o_ready) begin
        ok = 1'b1;
        break;
      end
      saw_block = 1'b1;
    end
    if (!ok) chk("accept_timeout", 64'(ok), 64'(1));
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    i_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic in_t rand_in();
    in_t x;
    int  r = $urandom_range(0, 7);
    x.sign = 1'($urandom);
    x.exp  = (r == 0) ? 8'h00 : (r == 1) ? 8'hFE : (r == 2) ? 8'hFF :
             (r == 3) ? 8'hFD : (r == 4) ? 8'h01 : 8'($urandom);
    r = $urandom_range(0, 3);
    x.mant = (r == 0) ? 24'hFFFFFF : (r == 1) ? 24'h7FFFFF : 24'($urandom);
    x.g    = 1'($urandom);
    x.s    = 1'($urandom);
    x.mode = 3'($urandom_range(0, 7));
    return x;
  endfunction

  task automatic wide_beat(input logic [10:0] e, input string tag,
                           input logic [10:0] want_e, input logic [52:0] want_m,
                           input logic want_ovf);
    bit ok = 1'b0;
    c2_exp = e; c2_mant = '1; c2_valid = 1'b1;
    @(posedge clk);
    #1;
    c2_valid = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (c2_ovalid) begin
        ok = 1'b1;
        break;
      end
    end
    chk({tag, "_valid"}, 64'(ok), 64'(1));
    chk({tag, "_exp"}, 64'(c2_oexp), 64'(want_e));
    chk({tag, "_mant"}, 64'(c2_omant), 64'(want_m));
    chk({tag, "_inexact"}, 64'(c2_oinexact), 64'(1));
    chk({tag, "_overflow"}, 64'(c2_ooverflow), 64'(want_ovf));
    chk({tag, "_sign"}, 64'(c2_osign), 64'(0));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    in_t dir[8];
    out_t lit[8];
    rst = 1'b1; i_valid = 1'b0;
    {i_sign, i_exp, i_mant, i_guard, i_sticky, i_mode} = '0;
    c2_valid = 1'b0; c2_exp = '0; c2_mant = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_o_valid", 64'(o_valid), 64'(0));
    chk("rst_o_ready", 64'(o_ready), 64'(1));
    chk("rst_fields", 64'({o_sign, o_exp, o_mant, o_inexact, o_overflow}), 64'(0));
    rst = 1'b0;
    idle(2);

    dir[0] = '{1'b0, 8'h7E, 24'hFFFFFF, 1'b1, 1'b0, 3'd0}; lit[0] = '{1'b0, 8'h7F, 24'h800000, 1'b1, 1'b0};
    dir[1] = '{1'b0, 8'h80, 24'h800002, 1'b1, 1'b0, 3'd0}; lit[1] = '{1'b0, 8'h80, 24'h800002, 1'b1, 1'b0};
    dir[2] = '{1'b0, 8'h80, 24'h800003, 1'b1, 1'b0, 3'd0}; lit[2] = '{1'b0, 8'h80, 24'h800004, 1'b1, 1'b0};
    dir[3] = '{1'b0, 8'hFE, 24'hFFFFFF, 1'b1, 1'b1, 3'd3}; lit[3] = '{1'b0, 8'hFF, 24'h000000, 1'b1, 1'b1};
    dir[4] = '{1'b0, 8'hFE, 24'hFFFFFF, 1'b1, 1'b1, 3'd1}; lit[4] = '{1'b0, 8'hFE, 24'hFFFFFF, 1'b1, 1'b0};
    dir[5] = '{1'b0, 8'hFE, 24'hFFFFFF, 1'b1, 1'b1, 3'd2}; lit[5] = '{1'b0, 8'hFE, 24'hFFFFFF, 1'b1, 1'b0};
    dir[6] = '{1'b0, 8'h00, 24'h7FFFFF, 1'b1, 1'b0, 3'd4}; lit[6] = '{1'b0, 8'h01, 24'h800000, 1'b1, 1'b0};
    dir[7] = '{1'b1, 8'hFF, 24'hC00000, 1'b1, 1'b0, 3'd0}; lit[7] = '{1'b1, 8'hFF, 24'hC00000, 1'b0, 1'b0};
    for (int k = 0; k < 8; k++) chk($sformatf("model_pin%0d", k), 64'(model(dir[k])), 64'(lit[k]));

    // First beat alone to pin the two-cycle latency.
    send(dir[0]);
    i_valid = 1'b0;
    @(negedge clk);
    chk("latency_c1", 64'(o_valid), 64'(0));
    @(negedge clk);
    chk("latency_c2", 64'(o_valid), 64'(1));
    chk("latency_mant", 64'(o_mant), 64'(24'h800000));
    @(posedge clk);
    #1;
    for (int k = 1; k < 8; k++) send(dir[k]);
    idle(5);

    // Eight back-to-back beats against a four-cycle downstream stall.
    saw_block = 1'b0;
    st_lo = cyc + 3;
    st_hi = cyc + 6;
    for (int k = 0; k < 8; k++) send(rand_in());
    idle(12);
    chk("bp_o_ready_dropped", 64'(saw_block), 64'(1));
    chk("bp_drained", 64'(q.size()), 64'(0));
    st_lo = 1 << 30;

    // Reset with two beats in flight.
    send(dir[0]);
    send(dir[2]);
    i_valid = 1'b0;
    chk("pre_rst_valid", 64'(o_valid), 64'(1));
    rst = 1'b1;
    #1;
    chk("midrst_o_valid", 64'(o_valid), 64'(0));
    chk("midrst_fields", 64'({o_sign, o_exp, o_mant, o_inexact, o_overflow}), 64'(0));
    q.delete();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(8);
    chk("post_rst_empty", 64'(q.size()), 64'(0));

    rand_rdy = 1'b1;
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      send(rand_in());
    end
    idle(2);
    rand_rdy = 1'b0;
    idle(10);
    chk("rand_drained", 64'(q.size()), 64'(0));

    wide_beat(11'h3FE, "wide_carry", 11'h3FF, 53'h10000000000000, 1'b0);
    wide_beat(11'h7FE, "wide_ovf", 11'h7FF, 53'h0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
